// File: rtl/hue_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hue_pkg                                                       |
// | Description : Shared types and helpers for the hue_pwm_array RGB driver:    |
// |               run modes, sector type, timing helpers and the hue-wheel to   |
// |               RGB component mapping.                                        |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package hue_pkg;

  // Widest colour resolution the shared mapping function handles.
  localparam int MAX_PWM_BITS = 12;
  localparam int MAX_HUE_W    = MAX_PWM_BITS + 3;

  typedef enum logic [1:0] {
    CYCLE   = 2'd0,
    HOLD    = 2'd1,
    BREATHE = 2'd2,
    OFF     = 2'd3
  } mode_e;

  typedef logic [2:0] sector_t;

  typedef struct packed {
    logic [MAX_PWM_BITS-1:0] r;
    logic [MAX_PWM_BITS-1:0] g;
    logic [MAX_PWM_BITS-1:0] b;
  } rgb_t;

  // Six sectors of 2^pwm_bits hue steps each.
  function automatic int hue_steps(input int pwm_bits);
    return 6 * (1 << pwm_bits);
  endfunction

  // Clocks per hue step, never below 1. The clock count per revolution is
  // formed by multiplying before dividing by 1000 so that sub-kHz clock rates
  // keep their precision; 64-bit maths avoids overflow at board clock rates.
  function automatic int step_div(input int clk_hz, input int cycle_ms,
                                  input int pwm_bits);
    longint clocks;
    longint div;
    clocks = (longint'(clk_hz) * longint'(cycle_ms)) / 64'sd1000;
    div    = clocks / longint'(hue_steps(pwm_bits));
    if (div < 64'sd1) begin
      div = 64'sd1;
    end
    return int'(div);
  endfunction

  // Hue position -> (R,G,B) components. Sector is the hue above the fraction
  // bits; within a sector one component ramps while the others sit at 0/MAXV.
  function automatic rgb_t hue_to_rgb(input logic [MAX_HUE_W-1:0] h,
                                      input int pwm_bits);
    logic [MAX_PWM_BITS-1:0] maxv;
    logic [MAX_PWM_BITS-1:0] f;
    sector_t                 s;
    rgb_t                    c;
    maxv = MAX_PWM_BITS'((1 << pwm_bits) - 1);
    f    = h[MAX_PWM_BITS-1:0] & maxv;
    s    = sector_t'(h >> pwm_bits);
    c    = '0;
    case (s)
      3'd0: begin c.r = maxv;     c.g = f;        c.b = '0;       end
      3'd1: begin c.r = maxv - f; c.g = maxv;     c.b = '0;       end
      3'd2: begin c.r = '0;       c.g = maxv;     c.b = f;        end
      3'd3: begin c.r = '0;       c.g = maxv - f; c.b = maxv;     end
      3'd4: begin c.r = f;        c.g = '0;       c.b = maxv;     end
      3'd5: begin c.r = maxv;     c.g = '0;       c.b = maxv - f; end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_channel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : pwm_channel                                                   |
// | Description : One PWM output. Duty is captured only when i_latch is high    |
// |               (period boundary) so every period shows a whole pulse.        |
// | Ports       : clk     - system clock                                        |
// |               rst_n   - asynchronous active-low reset                       |
// |               i_cnt   - shared free-running PWM counter                     |
// |               i_duty  - next duty value                                     |
// |               i_latch - capture i_duty on this clock                        |
// |               o_pwm   - registered PWM pin (inverted when ACTIVE_LOW)       |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module pwm_channel #(
  parameter int PWM_BITS   = 8,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] i_cnt,
  input  logic [PWM_BITS-1:0] i_duty,
  input  logic                i_latch,
  output logic                o_pwm
);

  logic [PWM_BITS-1:0] r_duty;
  logic                r_on;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_duty <= '0;
      r_on   <= 1'b0;
    end else begin
      if (i_latch) begin
        r_duty <= i_duty;
      end
      r_on <= (i_cnt < r_duty);
    end
  end

  // Reset clears r_on, so the pin goes inactive immediately in either polarity.
  assign o_pwm = r_on ^ ACTIVE_LOW;

endmodule
`default_nettype wire

// File: rtl/hue_pwm_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : hue_pwm_array                                                 |
// | Description : Drives N_LEDS RGB LEDs around the hue wheel with evenly       |
// |               spaced phase offsets, PWM brightness and run modes            |
// |               (cycle / hold / breathe / off).                               |
// | Ports       : clk        - system clock                                     |
// |               SW         - asynchronous active-low reset (board switch)     |
// |               mode       - 0 cycle, 1 hold, 2 breathe, 3 off                |
// |               rgb_r/g/b  - PWM pins, one bit per LED                        |
// |               hue        - base hue of LED 0, 0..HUE_STEPS-1                |
// |               cycle_done - one-clock pulse when hue wraps to 0              |
// | Notes       : N_LEDS 1..8, PWM_BITS up to hue_pkg::MAX_PWM_BITS.            |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module hue_pwm_array
  import hue_pkg::*;
#(
  parameter int CLK_HZ     = 12000000,
  parameter int CYCLE_MS   = 1000,
  parameter int PWM_BITS   = 8,
  parameter int N_LEDS     = 1,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                clk,
  input  logic                SW,
  input  logic [1:0]          mode,
  output logic [N_LEDS-1:0]   rgb_r,
  output logic [N_LEDS-1:0]   rgb_g,
  output logic [N_LEDS-1:0]   rgb_b,
  output logic [PWM_BITS+2:0] hue,
  output logic                cycle_done
);

  localparam int c_HUE_W       = PWM_BITS + 3;
  localparam int c_HUE_STEPS   = hue_steps(PWM_BITS);
  localparam int c_STEP_DIV    = step_div(CLK_HZ, CYCLE_MS, PWM_BITS);
  localparam int c_DIV_W       = (c_STEP_DIV > 1) ? $clog2(c_STEP_DIV) : 1;
  localparam int c_LED_SPACING = c_HUE_STEPS / N_LEDS;

  localparam logic [PWM_BITS-1:0] c_MAXV      = '1;
  localparam logic [c_HUE_W:0]    c_STEPS_EXT = (c_HUE_W + 1)'(c_HUE_STEPS);

  mode_e w_mode;
  assign w_mode = mode_e'(mode);

  // ---------------------------------------------------------------------------
  // Step divider: free-running in every mode.
  // ---------------------------------------------------------------------------
  logic [c_DIV_W-1:0] r_div;
  logic               w_tick;

  assign w_tick = (r_div == c_DIV_W'(c_STEP_DIV - 1));

  always_ff @(posedge clk or negedge SW) begin
    if (!SW) begin
      r_div <= '0;
    end else if (w_tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + c_DIV_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Hue counter and wrap pulse (advances only in cycle mode).
  // ---------------------------------------------------------------------------
  logic [c_HUE_W-1:0] r_hue;
  logic               r_cycle_done;
  logic               w_hue_adv;
  logic               w_hue_last;

  assign w_hue_adv  = w_tick && (w_mode == CYCLE);
  assign w_hue_last = (r_hue == c_HUE_W'(c_HUE_STEPS - 1));

  always_ff @(posedge clk or negedge SW) begin
    if (!SW) begin
      r_hue        <= '0;
      r_cycle_done <= 1'b0;
    end else begin
      // Pulse lands on the same clock the registered hue becomes 0.
      r_cycle_done <= w_hue_adv && w_hue_last;
      if (w_hue_adv) begin
        r_hue <= w_hue_last ? '0 : r_hue + c_HUE_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Breathe level: triangle 0..MAXV..0, stepping only while breathing so a
  // return to breathe mode resumes from where it stopped.
  // ---------------------------------------------------------------------------
  logic [PWM_BITS-1:0] r_lvl;
  logic                r_lvl_up;

  always_ff @(posedge clk or negedge SW) begin
    if (!SW) begin
      r_lvl    <= '0;
      r_lvl_up <= 1'b1;
    end else if (w_tick && (w_mode == BREATHE)) begin
      if (r_lvl_up) begin
        r_lvl <= r_lvl + PWM_BITS'(1);
        if (r_lvl == c_MAXV - PWM_BITS'(1)) begin
          r_lvl_up <= 1'b0;
        end
      end else begin
        r_lvl <= r_lvl - PWM_BITS'(1);
        if (r_lvl == PWM_BITS'(1)) begin
          r_lvl_up <= 1'b1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Shared PWM counter; duties are captured as it rolls over to 0, so mode and
  // hue changes only ever show up at a period boundary.
  // ---------------------------------------------------------------------------
  logic [PWM_BITS-1:0] r_cnt;
  logic                w_latch;

  assign w_latch = (r_cnt == c_MAXV);

  always_ff @(posedge clk or negedge SW) begin
    if (!SW) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + PWM_BITS'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-LED colour and PWM channels.
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < N_LEDS; i++) begin : g_led
    localparam logic [c_HUE_W:0] c_OFFSET = (c_HUE_W + 1)'(i * c_LED_SPACING);

    logic [c_HUE_W:0]         w_sum;
    logic [c_HUE_W-1:0]       w_h;
    rgb_t                     w_col;
    logic [2:0][PWM_BITS-1:0] w_c;
    logic [2:0]               w_pin;

    // Both terms are below HUE_STEPS, so one conditional subtract wraps.
    assign w_sum = {1'b0, r_hue} + c_OFFSET;
    assign w_h   = (w_sum >= c_STEPS_EXT) ? c_HUE_W'(w_sum - c_STEPS_EXT)
                                          : c_HUE_W'(w_sum);
    assign w_col = hue_to_rgb(MAX_HUE_W'(w_h), PWM_BITS);
    assign w_c   = {PWM_BITS'(w_col.b), PWM_BITS'(w_col.g), PWM_BITS'(w_col.r)};

    // Index 0 = red, 1 = green, 2 = blue.
    for (genvar j = 0; j < 3; j++) begin : g_col
      logic [2*PWM_BITS-1:0] w_prod;
      logic [PWM_BITS-1:0]   w_duty;

      assign w_prod = {{PWM_BITS{1'b0}}, w_c[j]} * {{PWM_BITS{1'b0}}, r_lvl};

      always_comb begin
        w_duty = w_c[j];
        case (w_mode)
          BREATHE: w_duty = PWM_BITS'(w_prod >> PWM_BITS);
          OFF:     w_duty = '0;
          default: w_duty = w_c[j];
        endcase
      end

      pwm_channel #(
        .PWM_BITS   (PWM_BITS),
        .ACTIVE_LOW (ACTIVE_LOW != 0)
      ) u_pwm (
        .clk     (clk),
        .rst_n   (SW),
        .i_cnt   (r_cnt),
        .i_duty  (w_duty),
        .i_latch (w_latch),
        .o_pwm   (w_pin[j])
      );
    end

    assign rgb_r[i] = w_pin[0];
    assign rgb_g[i] = w_pin[1];
    assign rgb_b[i] = w_pin[2];
  end

  assign hue        = r_hue;
  assign cycle_done = r_cycle_done;

endmodule
`default_nettype wire

// File: tb/tb_hue_pwm_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_hue_pwm_array                                              |
// | Description : Directed self-checking bench for hue_pwm_array with           |
// |               PWM_BITS=4, CLK_HZ=6144, CYCLE_MS=1000, N_LEDS=2, active-low. |
// |               HUE_STEPS=96, STEP_DIV=64. Edge k = k-th rising edge after    |
// |               reset release; outputs are sampled on the following negedge. |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_hue_pwm_array;

  logic       clk = 1'b0;
  logic       SW;
  logic [1:0] mode;
  logic [1:0] rgb_r;
  logic [1:0] rgb_g;
  logic [1:0] rgb_b;
  logic [6:0] hue;
  logic       cycle_done;

  int checks   = 0;
  int failures = 0;
  int edge_n   = 0;

  always #5 clk = ~clk;

  hue_pwm_array #(
    .CLK_HZ     (6144),
    .CYCLE_MS   (1000),
    .PWM_BITS   (4),
    .N_LEDS     (2),
    .ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .SW         (SW),
    .mode       (mode),
    .rgb_r      (rgb_r),
    .rgb_g      (rgb_g),
    .rgb_b      (rgb_b),
    .hue        (hue),
    .cycle_done (cycle_done)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    edge_n++;
  endtask

  task automatic wait_to(input int target);
    while (edge_n < target) step();
  endtask

  // Reset asserted, then released on a negedge; next posedge is edge 1.
  task automatic do_reset();
    @(negedge clk);
    SW = 1'b0;
    repeat (3) @(negedge clk);
    SW = 1'b1;
    edge_n = 0;
  endtask

  task automatic test_reset();
    SW   = 1'b0;
    mode = 2'd0;
    repeat (10) @(negedge clk);
    checks++;
    if ({rgb_r, rgb_g, rgb_b} !== 6'h3F) begin
      failures++;
      $display("FAIL reset_pins: got %h expected 3f", {rgb_r, rgb_g, rgb_b});
    end
    checks++;
    if (hue !== 7'd0) begin
      failures++;
      $display("FAIL reset_hue: got %0d expected 0", hue);
    end
    checks++;
    if (cycle_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_cycle_done: got %b expected 0", cycle_done);
    end
    SW = 1'b1;
    edge_n = 0;
    wait_to(70);
    checks++;
    if (hue !== 7'd1) begin
      failures++;
      $display("FAIL pre_reset_hue: got %0d expected 1", hue);
    end
    checks++;
    if (rgb_r[0] !== 1'b0) begin
      failures++;
      $display("FAIL pre_reset_red_lit: got %b expected 0", rgb_r[0]);
    end
    // Async reset between clock edges.
    #2 SW = 1'b0;
    #1;
    checks++;
    if ({rgb_r, rgb_g, rgb_b} !== 6'h3F) begin
      failures++;
      $display("FAIL async_reset_pins: got %h expected 3f", {rgb_r, rgb_g, rgb_b});
    end
    checks++;
    if (hue !== 7'd0) begin
      failures++;
      $display("FAIL async_reset_hue: got %0d expected 0", hue);
    end
    @(negedge clk);
  endtask

  task automatic test_hue_sweep();
    int pulses = 0;
    int err_h  = 0;
    int err_cd = 0;
    do_reset();
    mode = 2'd0;
    for (int k = 1; k <= 12288; k++) begin
      step();
      if (cycle_done === 1'b1) pulses++;
      if (cycle_done !== ((edge_n % 6144) == 0)) err_cd++;
      if (hue !== 7'((edge_n / 64) % 96)) err_h++;
      if (edge_n == 64) begin
        checks++;
        if (hue !== 7'd1) begin
          failures++;
          $display("FAIL sweep_hue_at_64: got %0d expected 1", hue);
        end
      end
      if (edge_n == 6080) begin
        checks++;
        if (hue !== 7'd95) begin
          failures++;
          $display("FAIL sweep_hue_at_6080: got %0d expected 95", hue);
        end
      end
      if (edge_n == 6144) begin
        checks++;
        if ({cycle_done, hue} !== {1'b1, 7'd0}) begin
          failures++;
          $display("FAIL sweep_wrap_6144: got done=%b hue=%0d expected done=1 hue=0",
                   cycle_done, hue);
        end
      end
    end
    checks++;
    if (pulses !== 2) begin
      failures++;
      $display("FAIL sweep_pulse_count: got %0d expected 2", pulses);
    end
    checks++;
    if (err_cd !== 0) begin
      failures++;
      $display("FAIL sweep_cycle_done_trace: got %0d bad clocks expected 0", err_cd);
    end
    checks++;
    if (err_h !== 0) begin
      failures++;
      $display("FAIL sweep_hue_trace: got %0d bad clocks expected 0", err_h);
    end
  endtask

  task automatic test_colour();
    int lit [6];
    int exp_lit [6] = '{15, 0, 0, 0, 15, 15};  // r0 g0 b0 r1 g1 b1
    for (int n = 0; n < 6; n++) lit[n] = 0;
    do_reset();
    mode = 2'd0;
    wait_to(16);
    for (int k = 0; k < 16; k++) begin
      step();
      if (rgb_r[0] === 1'b0) lit[0]++;
      if (rgb_g[0] === 1'b0) lit[1]++;
      if (rgb_b[0] === 1'b0) lit[2]++;
      if (rgb_r[1] === 1'b0) lit[3]++;
      if (rgb_g[1] === 1'b0) lit[4]++;
      if (rgb_b[1] === 1'b0) lit[5]++;
    end
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (lit[n] !== exp_lit[n]) begin
        failures++;
        $display("FAIL colour_ch%0d_on_clocks: got %0d expected %0d", n, lit[n], exp_lit[n]);
      end
    end
  endtask

  task automatic test_hold();
    int lit [6];
    // hue 20: LED0 s1 f4 -> (11,15,0); LED1 h68 s4 f4 -> (4,0,15); x625 periods
    int exp_lit [6] = '{6875, 9375, 0, 2500, 0, 9375};
    int err_h  = 0;
    int err_cd = 0;
    for (int n = 0; n < 6; n++) lit[n] = 0;
    do_reset();
    mode = 2'd0;
    wait_to(1280);
    checks++;
    if (hue !== 7'd20) begin
      failures++;
      $display("FAIL hold_start_hue: got %0d expected 20", hue);
    end
    mode = 2'd1;
    wait_to(1296);
    for (int k = 0; k < 10000; k++) begin
      step();
      if (hue !== 7'd20) err_h++;
      if (cycle_done !== 1'b0) err_cd++;
      if (rgb_r[0] === 1'b0) lit[0]++;
      if (rgb_g[0] === 1'b0) lit[1]++;
      if (rgb_b[0] === 1'b0) lit[2]++;
      if (rgb_r[1] === 1'b0) lit[3]++;
      if (rgb_g[1] === 1'b0) lit[4]++;
      if (rgb_b[1] === 1'b0) lit[5]++;
    end
    checks++;
    if (err_h !== 0) begin
      failures++;
      $display("FAIL hold_hue_frozen: got %0d bad clocks expected 0", err_h);
    end
    checks++;
    if (err_cd !== 0) begin
      failures++;
      $display("FAIL hold_no_cycle_done: got %0d pulses expected 0", err_cd);
    end
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (lit[n] !== exp_lit[n]) begin
        failures++;
        $display("FAIL hold_ch%0d_on_clocks: got %0d expected %0d", n, lit[n], exp_lit[n]);
      end
    end
  endtask

  task automatic test_breathe_off();
    // (15*L)>>4 for L = 0..15
    int exp_br [16] = '{0, 0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14};
    int lit;
    int lvl;
    int err;
    do_reset();
    mode = 2'd2;
    for (int m = 0; m <= 20; m++) begin
      lvl = (m <= 15) ? m : 30 - m;
      wait_to(64 * m + 16);
      lit = 0;
      for (int k = 0; k < 16; k++) begin
        step();
        if (rgb_r[0] === 1'b0) lit++;
      end
      checks++;
      if (lit !== exp_br[lvl]) begin
        failures++;
        $display("FAIL breathe_step%0d_red_on: got %0d expected %0d", m, lit, exp_br[lvl]);
      end
    end
    // Period latched at edge 1312 has L=10 -> duty 9; switch to off at cnt=7.
    wait_to(1319);
    mode = 2'd3;
    step();
    checks++;
    if (rgb_r[0] !== 1'b0) begin
      failures++;
      $display("FAIL off_no_early_change_1320: got %b expected 0", rgb_r[0]);
    end
    step();
    checks++;
    if (rgb_r[0] !== 1'b0) begin
      failures++;
      $display("FAIL off_no_early_change_1321: got %b expected 0", rgb_r[0]);
    end
    step();
    checks++;
    if (rgb_r[0] !== 1'b1) begin
      failures++;
      $display("FAIL off_duty_end_1322: got %b expected 1", rgb_r[0]);
    end
    wait_to(1328);
    err = 0;
    for (int k = 0; k < 32; k++) begin
      step();
      if ({rgb_r, rgb_g, rgb_b} !== 6'h3F) err++;
    end
    checks++;
    if (err !== 0) begin
      failures++;
      $display("FAIL off_all_dark: got %0d lit clocks expected 0", err);
    end
  endtask

  task automatic test_glitch_free();
    int err;
    int lit;
    do_reset();
    mode = 2'd0;
    wait_to(39);
    mode = 2'd3;
    err = 0;
    for (int k = 40; k <= 47; k++) begin
      step();
      if (rgb_r[0] !== 1'b0 || rgb_g[1] !== 1'b0 || rgb_b[1] !== 1'b0) err++;
    end
    checks++;
    if (err !== 0) begin
      failures++;
      $display("FAIL glitch_hold_until_wrap: got %0d changed clocks expected 0", err);
    end
    step();
    checks++;
    if ({rgb_r, rgb_g, rgb_b} !== 6'h3F) begin
      failures++;
      $display("FAIL glitch_period_end_48: got %h expected 3f", {rgb_r, rgb_g, rgb_b});
    end
    err = 0;
    for (int k = 49; k <= 64; k++) begin
      step();
      if ({rgb_r, rgb_g, rgb_b} !== 6'h3F) err++;
    end
    checks++;
    if (err !== 0) begin
      failures++;
      $display("FAIL glitch_off_period: got %0d lit clocks expected 0", err);
    end
    wait_to(71);
    mode = 2'd0;
    err = 0;
    for (int k = 72; k <= 80; k++) begin
      step();
      if ({rgb_r, rgb_g, rgb_b} !== 6'h3F) err++;
    end
    checks++;
    if (err !== 0) begin
      failures++;
      $display("FAIL glitch_resume_waits: got %0d lit clocks expected 0", err);
    end
    lit = 0;
    for (int k = 81; k <= 96; k++) begin
      step();
      if (rgb_r[0] === 1'b0) lit++;
    end
    checks++;
    if (lit !== 15) begin
      failures++;
      $display("FAIL glitch_resume_red_on: got %0d expected 15", lit);
    end
  endtask

  initial begin
    SW   = 1'b0;
    mode = 2'd0;
    test_reset();
    test_hue_sweep();
    test_colour();
    test_hold();
    test_breathe_off();
    test_glitch_free();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
